// File: rtl/dh_pkg.sv
// Shared types and default tuning constants for the duck-hunt round controller.
package dh_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    FLY,
    HIT_HOLD,
    NEXT,
    ROUND_END,
    GAME_OVER
  } round_state_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int DEF_DUCKS_PER_ROUND = 10;
  localparam int DEF_SHOTS_PER_DUCK  = 3;
  localparam int DEF_ESCAPE_FRAMES   = 300;
  localparam int DEF_HIT_HOLD_FRAMES = 60;
  localparam int DEF_PASS_HITS       = 6;
  localparam int DEF_SCORE_DIGITS    = 2;

endpackage

// File: rtl/ctl_round_if.sv
// Game-flow signal bundle between the trigger/frame sources and the round controller.
interface ctl_round_if
  import dh_pkg::*;
#(
  parameter int SCORE_DIGITS = DEF_SCORE_DIGITS
);
  logic                      new_frame;
  logic                      pause;
  logic                      reload;
  logic                      shot_fired;
  logic                      hit;
  logic                      duck_spawn;
  logic                      duck_active;
  logic                      duck_escaped;
  logic                      no_ammo;
  logic [2:0]                shots_left;
  logic [3:0]                ducks_left;
  logic [7:0]                round_num;
  logic [4*SCORE_DIGITS-1:0] score_bcd;
  logic                      round_won;
  logic                      game_over;

  modport master (
    output new_frame, pause, reload, shot_fired, hit,
    input  duck_spawn, duck_active, duck_escaped, no_ammo, shots_left,
           ducks_left, round_num, score_bcd, round_won, game_over
  );

  modport slave (
    input  new_frame, pause, reload, shot_fired, hit,
    output duck_spawn, duck_active, duck_escaped, no_ammo, shots_left,
           ducks_left, round_num, score_bcd, round_won, game_over
  );
endinterface

// File: rtl/ctl_round_bcd_counter.sv
// Multi-digit BCD incrementer; at all-9s it either holds (sat=1) or reloads INIT.
module bcd_counter
  import dh_pkg::*;
#(
  parameter int                  DIGITS = 2,
  parameter logic [4*DIGITS-1:0] INIT   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  inc,
  input  logic                  sat,
  output logic [4*DIGITS-1:0]   value
);
  logic [DIGITS:0]     carry;
  logic [4*DIGITS-1:0] sum;

  assign carry[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      bcd_digit_t d;
      assign d               = value[4*gi +: 4];
      assign carry[gi+1]     = carry[gi] && (d == 4'd9);
      assign sum[4*gi +: 4]  = !carry[gi] ? d : ((d == 4'd9) ? 4'd0 : d + 4'd1);
    end
  endgenerate

  // carry out of the top digit means every digit is 9
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= INIT;
    end else if (clr) begin
      value <= INIT;
    end else if (inc) begin
      if (!carry[DIGITS]) value <= sum;
      else if (!sat)      value <= INIT;
    end
  end
endmodule

// File: rtl/ctl_round.sv
// Round sequencer: spawns ducks, tracks shots/escapes/hits, keeps BCD score and round.
module ctl_round
  import dh_pkg::*;
#(
  parameter int DUCKS_PER_ROUND = DEF_DUCKS_PER_ROUND,
  parameter int SHOTS_PER_DUCK  = DEF_SHOTS_PER_DUCK,
  parameter int ESCAPE_FRAMES   = DEF_ESCAPE_FRAMES,
  parameter int HIT_HOLD_FRAMES = DEF_HIT_HOLD_FRAMES,
  parameter int PASS_HITS       = DEF_PASS_HITS,
  parameter int SCORE_DIGITS    = DEF_SCORE_DIGITS
) (
  input logic        clk,
  input logic        rst,
  ctl_round_if.slave bus
);
  localparam int MAX_FRAMES = (ESCAPE_FRAMES > HIT_HOLD_FRAMES) ? ESCAPE_FRAMES : HIT_HOLD_FRAMES;
  localparam int FW         = $clog2(MAX_FRAMES + 1);
  localparam logic [FW-1:0] ESC_LAST  = FW'(ESCAPE_FRAMES - 1);
  localparam logic [FW-1:0] HOLD_LAST = FW'(HIT_HOLD_FRAMES - 1);

  round_state_t  state_reg, state_next;
  logic [FW-1:0] frame_reg, frame_next;
  logic [2:0]    shots_reg, shots_next;
  logic [3:0]    ducks_reg, ducks_next;
  logic [3:0]    hits_reg, hits_next;
  logic          escaped_next, score_inc, round_inc, run;
  logic          spawn_reg, active_reg, escaped_reg, no_ammo_reg, won_reg, over_reg;
  logic [4*SCORE_DIGITS-1:0] score_value;
  logic [7:0]    round_value;

  assign run = !bus.pause;

  always_comb begin
    state_next   = state_reg;
    frame_next   = frame_reg;
    shots_next   = shots_reg;
    ducks_next   = ducks_reg;
    hits_next    = hits_reg;
    escaped_next = 1'b0;
    score_inc    = 1'b0;
    round_inc    = 1'b0;
    if (bus.reload) begin
      state_next = IDLE;
      hits_next  = '0;
    end else begin
      case (state_reg)
        IDLE: if (run) begin
          state_next = SPAWN;
          ducks_next = 4'(DUCKS_PER_ROUND);
          hits_next  = '0;
        end
        // SPAWN ignores pause so the spawn pulse is never stretched
        SPAWN: begin
          state_next = FLY;
          shots_next = 3'(SHOTS_PER_DUCK);
          frame_next = '0;
          ducks_next = ducks_reg - 4'd1;
        end
        FLY: if (run) begin
          if (bus.shot_fired && shots_reg != 3'd0) shots_next = shots_reg - 3'd1;
          if (bus.hit) begin
            score_inc  = 1'b1;
            hits_next  = hits_reg + 4'd1;
            frame_next = '0;
            state_next = HIT_HOLD;
          end else if ((shots_reg == 3'd0 && !bus.shot_fired) ||
                       (bus.new_frame && frame_reg == ESC_LAST)) begin
            escaped_next = 1'b1;
            state_next   = NEXT;
          end else if (bus.new_frame) begin
            frame_next = frame_reg + FW'(1);
          end
        end
        HIT_HOLD: if (run && bus.new_frame) begin
          if (frame_reg == HOLD_LAST) state_next = NEXT;
          else                        frame_next = frame_reg + FW'(1);
        end
        NEXT: if (run) begin
          frame_next = '0;
          state_next = (ducks_reg == 4'd0) ? ROUND_END : SPAWN;
        end
        ROUND_END: if (run && bus.new_frame) begin
          if (frame_reg == HOLD_LAST) begin
            if (hits_reg >= 4'(PASS_HITS)) begin
              round_inc  = 1'b1;
              state_next = IDLE;
            end else begin
              state_next = GAME_OVER;
            end
          end else begin
            frame_next = frame_reg + FW'(1);
          end
        end
        GAME_OVER: state_next = GAME_OVER;
        default:   state_next = IDLE;
      endcase
    end
  end

  // Outputs are loaded from next-state values so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      frame_reg   <= '0;
      shots_reg   <= '0;
      ducks_reg   <= '0;
      hits_reg    <= '0;
      spawn_reg   <= 1'b0;
      active_reg  <= 1'b0;
      escaped_reg <= 1'b0;
      no_ammo_reg <= 1'b0;
      won_reg     <= 1'b0;
      over_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      frame_reg   <= frame_next;
      shots_reg   <= shots_next;
      ducks_reg   <= ducks_next;
      hits_reg    <= hits_next;
      spawn_reg   <= (state_next == SPAWN);
      active_reg  <= (state_next == FLY);
      escaped_reg <= escaped_next;
      no_ammo_reg <= (state_next == FLY) && (shots_next == 3'd0);
      won_reg     <= (state_next == ROUND_END) && (hits_next >= 4'(PASS_HITS));
      over_reg    <= (state_next == GAME_OVER);
    end
  end

  bcd_counter #(.DIGITS(SCORE_DIGITS), .INIT('0)) u_score (
    .clk(clk), .rst(rst), .clr(bus.reload), .inc(score_inc), .sat(1'b1), .value(score_value)
  );

  bcd_counter #(.DIGITS(2), .INIT(8'h01)) u_round (
    .clk(clk), .rst(rst), .clr(bus.reload), .inc(round_inc), .sat(1'b0), .value(round_value)
  );

  assign bus.duck_spawn   = spawn_reg;
  assign bus.duck_active  = active_reg;
  assign bus.duck_escaped = escaped_reg;
  assign bus.no_ammo      = no_ammo_reg;
  assign bus.shots_left   = shots_reg;
  assign bus.ducks_left   = ducks_reg;
  assign bus.round_num    = round_value;
  assign bus.score_bcd    = score_value;
  assign bus.round_won    = won_reg;
  assign bus.game_over    = over_reg;
endmodule

// File: doc/ctl_round.md
Name: ctl_round

Overview:
- Parametrised game-flow controller that generalises the fixed score/ammo/pause bookkeeping into a full round sequencer.
- Tracks N ducks per round, shots per duck, escape timeout, hits per round, BCD score and round number, and issues duck spawn/escape commands.
- Sits in the ctrl section.
  - Inputs: ctl_trigger (hit, shot_fired), ctl_pause and ctl_reload.
  - Outputs: ctl_duck, draw_overlay and disp_hex_mux.

Parameters:
- DUCKS_PER_ROUND, 10, ducks spawned per round (1..15).
- SHOTS_PER_DUCK, 3, shots allowed per duck (1..7).
- ESCAPE_FRAMES, 300, frames before an unhit duck escapes.
- HIT_HOLD_FRAMES, 60, frames the hit duck is held before the next spawn.
- PASS_HITS, 6, minimum hits per round to advance (≤ DUCKS_PER_ROUND).
- SCORE_DIGITS, 2, BCD digits of score (1..4).

Ports:
- clk  in  1  system clock 65 MHz
- rst  in  1  asynchronous reset, active-high
- new_frame  in  1  one-cycle pulse per VGA frame
- pause  in  1  level; freezes all game progress
- reload  in  1  one-cycle pulse; restarts the game
- shot_fired  in  1  one-cycle pulse per shot
- hit  in  1  one-cycle pulse when a shot hits the duck
- duck_spawn  out  1  one-cycle pulse: start a new duck
- duck_active  out  1  duck in flight and shootable
- duck_escaped  out  1  one-cycle pulse: duck flew away
- no_ammo  out  1  shots_left==0 while in FLY
- shots_left  out  3  remaining shots for current duck
- ducks_left  out  4  ducks still to spawn this round
- round_num  out  8  BCD round number, 2 digits
- score_bcd  out  4*SCORE_DIGITS  BCD score, LS digit in [3:0]
- round_won  out  1  level; in ROUND_END with pass
- game_over  out  1  level; in GAME_OVER

Behaviour:
- Reset (async): state=IDLE; all outputs 0 except round_num=8'h01.
- FSM states, all registered; outputs are registered, so there is 1 cycle of latency from an input event:
  - IDLE: next cycle go to SPAWN. ducks_left=DUCKS_PER_ROUND; hits_in_round=0.
  - SPAWN: duck_spawn=1 for exactly one cycle. shots_left=SHOTS_PER_DUCK; frame_cnt=0; ducks_left-=1. Go to FLY.
  - FLY: duck_active=1.
    - shot_fired decrements shots_left, saturating at 0.
    - hit: score+=1 (BCD, saturating at all-9s); hits_in_round+=1; frame_cnt=0; go to HIT_HOLD.
    - Else, if shots_left==0 and no shot pending, or frame_cnt==ESCAPE_FRAMES-1 on new_frame: duck_escaped pulse; go to NEXT.
  - HIT_HOLD: count new_frame up to HIT_HOLD_FRAMES, then go to NEXT.
  - NEXT: if ducks_left==0 go to ROUND_END, else go to SPAWN.
  - ROUND_END: round_won=(hits_in_round>=PASS_HITS), held for HIT_HOLD_FRAMES frames.
    - On pass: round_num BCD+1 (99 wraps to 01), then go to IDLE.
    - On fail: go to GAME_OVER.
  - GAME_OVER: game_over=1; stays until reload.
- Simultaneous events:
  - hit and shot_fired in the same cycle: both apply (shot decremented, hit counted); hit takes priority over escape.
  - hit on the last shot counts as a hit, not an escape.
  - hit outside FLY is ignored. shot_fired outside FLY is ignored.
  - Escape timeout and hit in the same cycle: hit wins.
- pause=1:
  - frame counters hold.
  - shot_fired and hit are ignored.
  - The FSM holds in its current state, except that reload still acts.
  - A duck_spawn pulse already registered still completes.
- reload pulse, from any state and also during pause, acting synchronously:
  - score=0; round_num=01; hits_in_round=0; go to IDLE.
  - No duck_escaped is issued.
- Widths: frame counter $clog2(max(ESCAPE_FRAMES,HIT_HOLD_FRAMES)+1) bits. The BCD adder ripples carries across SCORE_DIGITS.

Decomposition:
- Package dh_pkg:
  - typedef enum round_state_t {IDLE, SPAWN, FLY, HIT_HOLD, NEXT, ROUND_END, GAME_OVER}.
  - BCD digit typedef.
  - Default constants for the parameters.
- One sub-module bcd_counter:
  - Parameter DIGITS.
  - Ports: clk, rst, clr, inc, saturate/wrap mode, value.
  - Used for both score (saturating) and round_num (wrapping).

Test Plan (bench params DUCKS=2, SHOTS=3, ESCAPE=4, HIT_HOLD=2, PASS=1):
- Reset released, no input → duck_spawn pulse within 2 cycles; shots_left=3, ducks_left=1, duck_active=1.
- 3 shot_fired pulses with no hit → shots_left 2,1,0; no_ammo=1; duck_escaped pulse; second duck spawns; score unchanged 00.
- hit and shot_fired in same cycle on 1st duck, then escape on 2nd → score=01; after ROUND_END round_won=1; round_num=02; new spawn.
- No shots for 4 frames on both ducks → two duck_escaped pulses; round_won=0; game_over=1 held; reload → score=00, round_num=01, spawn.
- pause=1 during FLY for 10 frames with shot/hit pulses → shots_left, score and frame counter unchanged; release → escape after the remaining frames.
- Score at 99 (SCORE_DIGITS=2) plus hit → stays 99. Reload asserted during HIT_HOLD → IDLE next cycle, score=00.
